// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: controller state encodings,
// transfer direction codes and a pointer-width helper.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      DIR_READ  = 1'b0,
      DIR_WRITE = 1'b1
   } xfer_dir_t;

   // Width of a CPU index; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_select.sv
// Round-robin selector: returns the one-hot requester found first when
// scanning upward from ptr and wrapping around to CPU 0.
module rr_select
   import mem_bus_arbiter_pkg::*;
#(
   parameter int CPU_QUANTITY = 2,
   parameter int PTR_W        = ptr_width(CPU_QUANTITY)
) (
   input  logic [CPU_QUANTITY-1:0] req,
   input  logic [PTR_W-1:0]        ptr,
   output logic [CPU_QUANTITY-1:0] winner
);

   logic [CPU_QUANTITY-1:0] upper_req;
   logic [CPU_QUANTITY-1:0] pool;

   // Prefer requesters at or above ptr; if none, wrap to the lowest requester
   always_comb begin
      upper_req = '0;
      winner    = '0;
      for (int i = 0; i < CPU_QUANTITY; i++) begin
         if (PTR_W'(i) >= ptr) upper_req[i] = req[i];
      end
      pool = (|upper_req) ? upper_req : req;
      for (int i = CPU_QUANTITY - 1; i >= 0; i--) begin
         if (pool[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: grants one of CPU_QUANTITY CPUs access to a single
// memory port, round-robin, one transfer at a time (IDLE/GRANT/WAIT/DONE).
// Optional feature macro ARB_TIMEOUT_EN: abort a transfer whose memory
// completion has not arrived after TIMEOUT_CYCLES cycles in WAIT.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int CPU_QUANTITY   = 2,
   parameter int ADDR_SIZE      = 32,
   parameter int DATA_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CPU_QUANTITY-1:0]          read_q,
   input  logic [CPU_QUANTITY-1:0]          write_q,
   input  logic [CPU_QUANTITY*ADDR_SIZE-1:0] addr_in,
   input  logic [CPU_QUANTITY*DATA_SIZE-1:0] data_in,
   output logic [CPU_QUANTITY-1:0]          grant,
   output logic [CPU_QUANTITY-1:0]          read_dn,
   output logic [CPU_QUANTITY-1:0]          write_dn,
   output logic [DATA_SIZE-1:0]             data_out,
   output logic                             bus_busy,
   output logic                             ext_read_q,
   output logic                             ext_write_q,
   output logic [ADDR_SIZE-1:0]             ext_mem_addr,
   output logic [DATA_SIZE-1:0]             ext_mem_data_out,
   input  logic [DATA_SIZE-1:0]             ext_mem_data_in,
   input  logic                             ext_read_dn,
   input  logic                             ext_write_dn,
   output logic                             ext_rw_halt
);

   localparam int PTR_W = ptr_width(CPU_QUANTITY);

   arb_state_t              state, state_nxt;
   logic [CPU_QUANTITY-1:0] req_any;
   logic [CPU_QUANTITY-1:0] win_oh;
   logic [PTR_W-1:0]        win_idx;
   xfer_dir_t               dir_sel;
   logic [ADDR_SIZE-1:0]    addr_sel;
   logic [DATA_SIZE-1:0]    wdata_sel;

   logic [CPU_QUANTITY-1:0] owner_oh;
   logic [PTR_W-1:0]        owner_idx;
   xfer_dir_t               owner_dir;
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        next_ptr;

   logic [ADDR_SIZE-1:0]    addr_lat;
   logic [DATA_SIZE-1:0]    wdata_lat;
   logic [DATA_SIZE-1:0]    rdata_lat;

   logic                    start_xfer;
   logic                    xfer_ack;
   logic                    xfer_abort;

   assign req_any = read_q | write_q;

   rr_select #(
      .CPU_QUANTITY (CPU_QUANTITY),
      .PTR_W        (PTR_W)
   ) u_rr_select (
      .req    (req_any),
      .ptr    (rr_ptr),
      .winner (win_oh)
   );

   // Route the winner's index, direction (read wins over write), address and data
   always_comb begin
      win_idx   = '0;
      dir_sel   = DIR_WRITE;
      addr_sel  = '0;
      wdata_sel = '0;
      for (int i = 0; i < CPU_QUANTITY; i++) begin
         if (win_oh[i]) begin
            win_idx   = PTR_W'(i);
            dir_sel   = read_q[i] ? DIR_READ : DIR_WRITE;
            addr_sel  = addr_in[i*ADDR_SIZE +: ADDR_SIZE];
            wdata_sel = data_in[i*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   assign start_xfer = (state == ST_IDLE) && (|req_any);

   // Only the completion matching the latched direction retires the transfer;
   // it is accepted from the very first WAIT cycle.
   assign xfer_ack = (state == ST_WAIT) &&
                     ((owner_dir == DIR_READ) ? ext_read_dn : ext_write_dn);

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   // Count cycles spent in WAIT; restarts for every transfer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  to_cnt <= '0;
      else if (state == ST_WAIT) to_cnt <= to_cnt + 1'b1;
      else                       to_cnt <= '0;
   end

   // A completion in the final cycle still wins over the abort
   assign xfer_abort = (state == ST_WAIT) && !xfer_ack &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
   assign xfer_abort     = 1'b0;
`endif

   assign ext_rw_halt = xfer_abort;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (|req_any) state_nxt = ST_GRANT;
         ST_GRANT: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (xfer_ack)        state_nxt = ST_DONE;
            else if (xfer_abort) state_nxt = ST_IDLE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign next_ptr = (owner_idx == PTR_W'(CPU_QUANTITY - 1)) ? '0 : owner_idx + 1'b1;

   // Capture ownership on entry to GRANT; move the pointer past the owner when it retires
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_oh  <= '0;
         owner_idx <= '0;
         owner_dir <= DIR_READ;
         rr_ptr    <= '0;
      end else begin
         if (start_xfer) begin
            owner_oh  <= win_oh;
            owner_idx <= win_idx;
            owner_dir <= dir_sel;
         end
         if ((state == ST_DONE) || xfer_abort) rr_ptr <= next_ptr;
      end
   end

   // Transfer payload; outputs are gated by state so these need no reset
   always_ff @(posedge clk) begin
      if (start_xfer) begin
         addr_lat  <= addr_sel;
         wdata_lat <= wdata_sel;
      end
      if (xfer_ack && (owner_dir == DIR_READ)) rdata_lat <= ext_mem_data_in;
   end

   assign bus_busy         = (state != ST_IDLE);
   assign grant            = bus_busy ? owner_oh : '0;
   assign ext_read_q       = (state == ST_WAIT) && (owner_dir == DIR_READ);
   assign ext_write_q      = (state == ST_WAIT) && (owner_dir == DIR_WRITE);
   assign ext_mem_addr     = bus_busy ? addr_lat : '0;
   assign ext_mem_data_out = (bus_busy && (owner_dir == DIR_WRITE)) ? wdata_lat : '0;
   assign read_dn          = ((state == ST_DONE) && (owner_dir == DIR_READ))  ? owner_oh : '0;
   assign write_dn         = ((state == ST_DONE) && (owner_dir == DIR_WRITE)) ? owner_oh : '0;
   assign data_out         = ((state == ST_DONE) && (owner_dir == DIR_READ))  ? rdata_lat : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (two CPUs, TIMEOUT_CYCLES=4). Timeout
// scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    read_q = '0, write_q = '0;
   logic [N*AW-1:0] addr_in = '0;
   logic [N*DW-1:0] data_in = '0;
   logic [N-1:0]    grant, read_dn, write_dn;
   logic [DW-1:0]   data_out;
   logic            bus_busy, ext_read_q, ext_write_q, ext_rw_halt;
   logic [AW-1:0]   ext_mem_addr;
   logic [DW-1:0]   ext_mem_data_out;
   logic [DW-1:0]   ext_mem_data_in = '0;
   logic            ext_read_dn = 1'b0, ext_write_dn = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .CPU_QUANTITY(N), .ADDR_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .read_q(read_q), .write_q(write_q),
      .addr_in(addr_in), .data_in(data_in), .grant(grant),
      .read_dn(read_dn), .write_dn(write_dn), .data_out(data_out),
      .bus_busy(bus_busy), .ext_read_q(ext_read_q), .ext_write_q(ext_write_q),
      .ext_mem_addr(ext_mem_addr), .ext_mem_data_out(ext_mem_data_out),
      .ext_mem_data_in(ext_mem_data_in), .ext_read_dn(ext_read_dn),
      .ext_write_dn(ext_write_dn), .ext_rw_halt(ext_rw_halt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: index where the round-robin scan starts
   int model_ptr = 0;

   function automatic int model_pick(input logic [N-1:0] req);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (model_ptr + k) % N;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   // Observations of one transfer
   bit            o_done, o_halted, o_rq, o_wq;
   int            o_lat, o_halt_at;
   logic [N-1:0]  o_g, o_rdn, o_wdn;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_wdata, o_dout;

   task automatic set_cpu(input int i, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      read_q[i]            = rd;
      write_q[i]           = wr;
      addr_in[i*AW +: AW]  = a;
      data_in[i*DW +: DW]  = d;
   endtask

   // Acts as memory: completes on WAIT cycle mem_lat (0 = first), optionally
   // throwing the wrong-direction completion pulse in the cycles before.
   task automatic observe(input int mem_lat, input logic [DW-1:0] rdata, input bit bogus);
      int wcnt;
      o_done = 0; o_halted = 0; o_rq = 0; o_wq = 0; o_lat = 0; o_halt_at = -1;
      o_g = '0; o_rdn = '0; o_wdn = '0; o_addr = '0; o_wdata = '0; o_dout = '0;
      wcnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         ext_read_dn  = 1'b0;
         ext_write_dn = 1'b0;
         if (bus_busy && o_g == '0) o_g = grant;
         if (ext_read_q || ext_write_q) begin
            o_addr  = ext_mem_addr;
            o_wdata = ext_mem_data_out;
            o_rq    = o_rq | ext_read_q;
            o_wq    = o_wq | ext_write_q;
            if (wcnt == mem_lat) begin
               ext_mem_data_in = rdata;
               if (ext_read_q) ext_read_dn = 1'b1; else ext_write_dn = 1'b1;
            end else if (bogus) begin
               if (ext_read_q) ext_write_dn = 1'b1; else ext_read_dn = 1'b1;
            end
            wcnt++;
            #1;
            if (ext_rw_halt) begin
               o_halted = 1; o_halt_at = wcnt - 1; o_lat = c;
               break;
            end
         end
         if ((|read_dn) || (|write_dn)) begin
            o_rdn = read_dn; o_wdn = write_dn; o_dout = data_out;
            o_lat = c; o_done = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({grant, read_dn, write_dn, bus_busy} !== '0) begin
         errors++; $display("FAIL reset_ctrl: got %h want 0", {grant, read_dn, write_dn, bus_busy});
      end
      checks++;
      if ({ext_read_q, ext_write_q, ext_rw_halt, ext_mem_addr} !== '0) begin
         errors++; $display("FAIL reset_ext: got %h want 0", {ext_read_q, ext_write_q, ext_rw_halt, ext_mem_addr});
      end
      checks++;
      if ({data_out, ext_mem_data_out} !== '0) begin
         errors++; $display("FAIL reset_data: got %h want 0", {data_out, ext_mem_data_out});
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_busy !== 1'b0) begin
         errors++; $display("FAIL idle_no_req: bus_busy=%b want 0", bus_busy);
      end
      model_ptr = 0;
   endtask

   task automatic test_single_read();
      set_cpu(1, 1'b1, 1'b0, 32'h10, 32'h0);
      observe(0, 32'hABCD, 0);
      read_q = '0;
      checks++;
      if (!o_done || o_g !== 2'b10 || o_addr !== 32'h10 || !o_rq || o_wq) begin
         errors++; $display("FAIL single_read_req: done=%0d grant=%b addr=%h rq=%0d wq=%0d want 1 10 10 1 0",
                            o_done, o_g, o_addr, o_rq, o_wq);
      end
      checks++;
      if (o_rdn !== 2'b10 || o_wdn !== 2'b00 || o_dout !== 32'hABCD) begin
         errors++; $display("FAIL single_read_dn: rdn=%b wdn=%b data=%h want 10 00 abcd", o_rdn, o_wdn, o_dout);
      end
      checks++;
      if (o_lat !== 3) begin
         errors++; $display("FAIL single_read_latency: got %0d want 3", o_lat);
      end
      model_ptr = (1 + 1) % N;
      @(negedge clk);
   endtask

   task automatic test_contention();
      int w;
      set_cpu(0, 1'b1, 1'b0, 32'h100, 32'h0);
      set_cpu(1, 1'b1, 1'b0, 32'h200, 32'h0);
      for (int t = 0; t < 4; t++) begin
         w = model_pick(read_q);
         observe(0, 32'h1000 + t, 0);
         checks++;
         if (!o_done || o_g !== (2'b01 << w) || o_rdn !== (2'b01 << w) || o_dout !== (32'h1000 + t)) begin
            errors++; $display("FAIL contention_%0d: done=%0d grant=%b rdn=%b data=%h want cpu%0d data %h",
                               t, o_done, o_g, o_rdn, o_dout, w, 32'h1000 + t);
         end
         checks++;
         if (o_lat !== ((t == 0) ? 3 : 4)) begin
            errors++; $display("FAIL contention_gap_%0d: latency %0d want %0d", t, o_lat, (t == 0) ? 3 : 4);
         end
         model_ptr = (w + 1) % N;
      end
      read_q = '0;
      @(negedge clk);
   endtask

   task automatic test_write();
      set_cpu(0, 1'b0, 1'b1, 32'h20, 32'h55);
      observe(2, 32'hDEAD, 0);
      write_q = '0;
      checks++;
      if (!o_done || !o_wq || o_rq || o_addr !== 32'h20 || o_wdata !== 32'h55) begin
         errors++; $display("FAIL write_req: done=%0d wq=%0d rq=%0d addr=%h data=%h want 1 1 0 20 55",
                            o_done, o_wq, o_rq, o_addr, o_wdata);
      end
      checks++;
      if (o_wdn !== 2'b01 || o_rdn !== 2'b00 || o_lat !== 5) begin
         errors++; $display("FAIL write_dn: wdn=%b rdn=%b latency=%0d want 01 00 5", o_wdn, o_rdn, o_lat);
      end
      model_ptr = 1;
      @(negedge clk);
   endtask

   task automatic test_read_priority();
      int w;
      set_cpu(0, 1'b1, 1'b1, 32'h30, 32'h77);
      w = model_pick(read_q | write_q);
      observe(1, 32'h1234, 0);
      read_q[0] = 1'b0;
      checks++;
      if (!o_done || !o_rq || o_wq || o_rdn !== (2'b01 << w) || o_dout !== 32'h1234) begin
         errors++; $display("FAIL priority_read: done=%0d rq=%0d wq=%0d rdn=%b data=%h want read by cpu%0d",
                            o_done, o_rq, o_wq, o_rdn, o_dout, w);
      end
      model_ptr = (w + 1) % N;
      w = model_pick(read_q | write_q);
      observe(0, 32'h0, 0);
      write_q = '0;
      checks++;
      if (!o_done || !o_wq || o_rq || o_wdn !== (2'b01 << w) || o_wdata !== 32'h77 || o_lat !== 4) begin
         errors++; $display("FAIL priority_write: done=%0d wq=%0d wdn=%b data=%h latency=%0d want write by cpu%0d",
                            o_done, o_wq, o_wdn, o_wdata, o_lat, w);
      end
      model_ptr = (w + 1) % N;
      @(negedge clk);
   endtask

   task automatic test_mismatch();
      set_cpu(1, 1'b1, 1'b0, 32'h44, 32'h0);
      observe(2, 32'h5A5A, 1);
      read_q = '0;
      checks++;
      if (!o_done || o_rdn !== 2'b10 || o_wdn !== 2'b00 || o_dout !== 32'h5A5A || o_lat !== 5) begin
         errors++; $display("FAIL mismatch: done=%0d rdn=%b wdn=%b data=%h latency=%0d want 1 10 00 5a5a 5",
                            o_done, o_rdn, o_wdn, o_dout, o_lat);
      end
      model_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_random();
      int w, lat;
      bit rd, bog;
      logic [DW-1:0] rdata;
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < N; i++)
            set_cpu(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
         if ((read_q | write_q) == '0) read_q[0] = 1'b1;
         w     = model_pick(read_q | write_q);
         rd    = read_q[w];
         lat   = $urandom_range(0, 2);
         bog   = 1'($urandom_range(0, 1));
         rdata = $urandom;
         observe(lat, rdata, bog);
         checks++;
         if (!o_done || o_g !== (2'b01 << w) || o_addr !== addr_in[w*AW +: AW] || o_rq !== rd || o_wq !== !rd) begin
            errors++; $display("FAIL random_%0d_req: done=%0d grant=%b addr=%h rq=%0d wq=%0d want cpu%0d addr=%h read=%0d",
                               it, o_done, o_g, o_addr, o_rq, o_wq, w, addr_in[w*AW +: AW], rd);
         end
         checks++;
         if ((rd ? o_rdn : o_wdn) !== (2'b01 << w) || (rd ? o_wdn : o_rdn) !== 2'b00 || o_lat !== 3 + lat) begin
            errors++; $display("FAIL random_%0d_dn: rdn=%b wdn=%b latency=%0d want cpu%0d read=%0d latency=%0d",
                               it, o_rdn, o_wdn, o_lat, w, rd, 3 + lat);
         end
         checks++;
         if (rd ? (o_dout !== rdata) : (o_wdata !== data_in[w*DW +: DW])) begin
            errors++; $display("FAIL random_%0d_data: got %h want %h", it, rd ? o_dout : o_wdata,
                               rd ? rdata : data_in[w*DW +: DW]);
         end
         model_ptr = (w + 1) % N;
         read_q = '0; write_q = '0;
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      int w;
      set_cpu(0, 1'b1, 1'b0, 32'h60, 32'h0);
      set_cpu(1, 1'b0, 1'b0, 32'h70, 32'h0);
      w = model_pick(read_q);
      observe(1000, 32'h0, 0);
      read_q = '0;
      checks++;
      if (!o_halted || o_done || o_halt_at !== TO - 1) begin
         errors++; $display("FAIL timeout_halt: halted=%0d done=%0d wait_cycle=%0d want 1 0 %0d",
                            o_halted, o_done, o_halt_at, TO - 1);
      end
      @(negedge clk);
      checks++;
      if (bus_busy !== 1'b0 || ext_read_q !== 1'b0 || ext_rw_halt !== 1'b0 || read_dn !== '0) begin
         errors++; $display("FAIL timeout_drop: busy=%b rq=%b halt=%b rdn=%b want all 0",
                            bus_busy, ext_read_q, ext_rw_halt, read_dn);
      end
      model_ptr = (w + 1) % N;
      read_q = 2'b11;
      w = model_pick(read_q);
      observe(0, 32'h0BAD, 0);
      read_q = '0;
      checks++;
      if (!o_done || o_g !== (2'b01 << w) || o_rdn !== (2'b01 << w)) begin
         errors++; $display("FAIL timeout_next_grant: done=%0d grant=%b rdn=%b want cpu%0d", o_done, o_g, o_rdn, w);
      end
      model_ptr = (w + 1) % N;
      @(negedge clk);
   endtask

   task automatic test_reset_midwait();
      int w;
      set_cpu(1, 1'b1, 1'b0, 32'h88, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ext_read_q !== 1'b1) begin
         errors++; $display("FAIL midwait_setup: ext_read_q=%b want 1", ext_read_q);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({grant, read_dn, write_dn, data_out, bus_busy, ext_read_q, ext_write_q,
           ext_mem_addr, ext_mem_data_out, ext_rw_halt} !== '0) begin
         errors++; $display("FAIL midwait_reset_outputs: grant=%b busy=%b rq=%b addr=%h want all 0",
                            grant, bus_busy, ext_read_q, ext_mem_addr);
      end
      read_q = '0;
      @(negedge clk);
      rst = 1'b1;
      model_ptr = 0;
      @(negedge clk);
      read_q = 2'b11;
      w = model_pick(read_q);
      observe(0, 32'h600D, 0);
      read_q = '0;
      checks++;
      if (!o_done || o_g !== (2'b01 << w) || o_g !== 2'b01 || o_dout !== 32'h600D) begin
         errors++; $display("FAIL midwait_first_grant: done=%0d grant=%b data=%h want 01 600d", o_done, o_g, o_dout);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_write();
      test_read_priority();
      test_mismatch();
      test_random();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_midwait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
